// File: rtl/stream_mux_arbiter.sv
// stream_mux_arbiter: N:1 valid/ready stream multiplexer.
// Picks one input channel, either by a fixed selector or by round-robin
// arbitration, and registers the winning word in a single-entry output slot.
// A new word may replace the slot in the same cycle that the slot drains,
// so one word per cycle can flow through.
module stream_mux_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic                      i_Mode,
    input  logic [SEL_WIDTH-1:0]      i_Selector,
    input  logic [CHANNELS-1:0]       i_Valid,
    input  logic [CHANNELS*WIDTH-1:0] i_Data,
    output logic [CHANNELS-1:0]       o_Ready,
    output logic                      o_Valid,
    output logic [WIDTH-1:0]          o_Data,
    output logic [SEL_WIDTH-1:0]      o_Channel,
    input  logic                      i_Ready
);

    // Channel reached after stepping 'off' positions past 'base', wrapping.
    function automatic int rr_index(input logic [SEL_WIDTH-1:0] base, input int off);
        return (int'(base) + off) % CHANNELS;
    endfunction

    logic [SEL_WIDTH-1:0] last_grant_r;
    logic                 load_s;
    logic                 grant_valid_s;
    logic [SEL_WIDTH-1:0] grant_idx_s;
    logic [WIDTH-1:0]     mux_data_s;
    logic                 in_xfer_s;

    // The slot can accept a word when it is empty or being drained this cycle.
    assign load_s = ~o_Valid | i_Ready;

    // An input transfer is exactly a raised ready; ready already implies valid.
    assign in_xfer_s = |o_Ready;

    // Grant decision: fixed selector in mode 0, round-robin after last_grant_r in mode 1.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        if (i_Mode == 1'b0) begin
            // An out-of-range selector matches no k, so it never grants.
            for (int k = 0; k < CHANNELS; k++) begin
                if ((i_Selector == SEL_WIDTH'(k)) && i_Valid[k]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = SEL_WIDTH'(k);
                end else begin
                    grant_valid_s = grant_valid_s;
                    grant_idx_s   = grant_idx_s;
                end
            end
        end else begin
            // Scan last_grant+1, last_grant+2, ... and keep the first valid hit.
            for (int off = 1; off <= CHANNELS; off++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (!grant_valid_s && (rr_index(last_grant_r, off) == k) && i_Valid[k]) begin
                        grant_valid_s = 1'b1;
                        grant_idx_s   = SEL_WIDTH'(k);
                    end else begin
                        grant_valid_s = grant_valid_s;
                        grant_idx_s   = grant_idx_s;
                    end
                end
            end
        end
    end

    // One-hot ready toward the granted channel, suppressed while in reset or stalled.
    always_comb begin
        o_Ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!i_Reset && load_s && grant_valid_s && (grant_idx_s == SEL_WIDTH'(k))) begin
                o_Ready[k] = 1'b1;
            end else begin
                o_Ready[k] = 1'b0;
            end
        end
    end

    // Data mux for the granted channel; only consumed when a transfer happens.
    always_comb begin
        mux_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx_s == SEL_WIDTH'(k)) begin
                mux_data_s = i_Data[k*WIDTH +: WIDTH];
            end else begin
                mux_data_s = mux_data_s;
            end
        end
    end

    // Output slot and round-robin pointer; reset overrides any transfer.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Valid      <= 1'b0;
            o_Data       <= '0;
            o_Channel    <= '0;
            last_grant_r <= SEL_WIDTH'(CHANNELS - 1);
        end else if (in_xfer_s) begin
            o_Valid   <= 1'b1;
            o_Data    <= mux_data_s;
            o_Channel <= grant_idx_s;
            // Fixed-select traffic must not disturb round-robin fairness.
            if (i_Mode) begin
                last_grant_r <= grant_idx_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end else if (o_Valid && i_Ready) begin
            // Drained with nothing to refill: data and channel keep their last values.
            o_Valid <= 1'b0;
        end else begin
            o_Valid      <= o_Valid;
            o_Data       <= o_Data;
            o_Channel    <= o_Channel;
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: doc/stream_mux_arbiter.md
Name: stream_mux_arbiter

Overview:
Parametrised N:1 stream multiplexer: successor to the 2:1 combinational selector test design. Selects one of CHANNELS valid/ready input streams by fixed selector or round-robin arbitration. Registers the chosen word in a single-entry output stage. Sits between producer channels and a single downstream consumer in the test designs mapped onto the fabric.

Parameters:
CHANNELS, 4, number of input channels (>= 2)
WIDTH, 8, data width per channel in bits
SEL_WIDTH, 2, selector/channel index width; must equal ceil(log2(CHANNELS))

Ports:
i_Clock  in  1  single clock; all state updates on rising edge
i_Reset  in  1  synchronous, active-high reset
i_Mode  in  1  0 = fixed select by i_Selector, 1 = round-robin
i_Selector  in  SEL_WIDTH  channel index used when i_Mode = 0
i_Valid  in  CHANNELS  per-channel valid, bit k = channel k
i_Data  in  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
o_Ready  out  CHANNELS  per-channel ready, at most one bit set
o_Valid  out  1  output word valid
o_Data  out  WIDTH  output word
o_Channel  out  SEL_WIDTH  index of the channel that produced o_Data
i_Ready  in  1  downstream ready

Behaviour:
- Reset (i_Reset high at edge): o_Valid=0, o_Data=0, o_Channel=0, round-robin pointer last_grant=CHANNELS-1, so channel 0 has first priority. Reset wins over any simultaneous transfer. o_Ready is 0 throughout any cycle where i_Reset is high.
- Transfers: an input transfer occurs on channel k when i_Valid[k] & o_Ready[k]. An output transfer occurs when o_Valid & i_Ready.
- load = ~o_Valid | i_Ready. The output slot is free or draining this cycle.
- Grant, combinational, from the current i_Valid, i_Mode, i_Selector and pointer:
  - Mode 0: grant = i_Selector if i_Selector < CHANNELS and i_Valid[i_Selector]; otherwise no grant. Out-of-range selector never grants.
  - Mode 1: grant = first k with i_Valid[k] set, scanning last_grant+1, last_grant+2, ... and wrapping modulo CHANNELS. Otherwise no grant.
- o_Ready = onehot(grant) when load and a grant exists; otherwise all zero. o_Ready may depend combinationally on i_Valid and i_Ready. It must not depend on i_Data.
- On an input transfer from k: next o_Data = channel k data, o_Channel = k, o_Valid = 1. The mux-to-output latency is 1 cycle.
- On an output transfer with no input transfer: o_Valid = 0. o_Data and o_Channel hold their last values.
- Simultaneous output and input transfer in the same cycle: the slot is replaced and o_Valid stays 1. This gives full throughput of 1 word/cycle.
- While o_Valid & ~i_Ready: o_Data, o_Channel and o_Valid are held stable and o_Ready = 0. No input is lost or duplicated.
- Pointer update: last_grant <= grant only on an input transfer while i_Mode = 1. Transfers in mode 0 leave the pointer unchanged.
- Mode or selector changes take effect for the next grant decision. A word already in the output slot is unaffected.
- With a single channel continuously valid in mode 1, that channel is granted every cycle. No idle cycles are inserted.
- Fairness: in mode 1 with all channels continuously valid and i_Ready=1, grants cycle 0,1,...,CHANNELS-1,0,...

Test Plan:
- Reset then mode 1, all 4 i_Valid=1, channel k data=8'hA0+k, i_Ready=1 -> o_Channel sequence 0,1,2,3,0,1 starting 1 cycle after the first grant; o_Valid continuously 1; o_Data A0,A1,A2,A3,A0.
- Mode 0, i_Selector=2, i_Valid=4'b1011 -> o_Ready=0, o_Valid stays 0. Then set i_Valid[2]=1 with data 8'h5C -> o_Ready=4'b0100; next cycle o_Data=5C, o_Channel=2.
- Backpressure: mode 1, i_Valid=4'b0110, i_Ready=0 for 3 cycles after the first load -> o_Data/o_Channel=1 held stable, o_Ready=0. Raise i_Ready -> next word from channel 2, then 1, with no loss or duplication (scoreboard).
- Round-robin wrap: pointer at 3 after a channel-3 grant, i_Valid=4'b1001 -> next grant channel 0, then 3; pointer unchanged by interleaved mode-0 transfers.
- Reset mid-stream: assert i_Reset for 1 cycle while o_Valid=1 and i_Ready=0 -> next cycle o_Valid=0, o_Data=0, o_Channel=0, o_Ready=0 during reset; first post-reset mode-1 grant with all valid goes to channel 0.
- Parameter sweep CHANNELS=2/WIDTH=1 (2:1 select) and CHANNELS=5/SEL_WIDTH=3 -> i_Selector=6 in mode 0 never grants; mode-1 rotation 0..4 wraps correctly.
